// File: rtl/uart_pkt_deframer_if.sv
// Byte-stream bundle between the RX FIFO, the packet deframer and the command decoder.
// Signal suffixes are from the deframer's point of view: the slave modport is the deframer.
interface uart_pkt_deframer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_vld_i;
    logic                  in_rdy_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_vld_o;
    logic                  out_rdy_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_last_o;
    logic                  pkt_ok_o;
    logic                  pkt_err_o;
    logic [1:0]            err_code_o;

    modport slave (
        input  in_vld_i, in_data_i, out_rdy_i,
        output in_rdy_o, out_vld_o, out_data_o, out_last_o, pkt_ok_o, pkt_err_o, err_code_o
    );

    modport master (
        output in_vld_i, in_data_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, out_data_o, out_last_o, pkt_ok_o, pkt_err_o, err_code_o
    );
endinterface

// File: rtl/uart_pkt_deframer.sv
// Extracts SYNC/LEN/payload/XOR-checksum frames from a byte stream, forwards payload
// cut-through with a last flag and pulses ok/error status once per frame.
module uart_pkt_deframer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5,
    parameter int                    MAX_LEN    = 16,
    parameter int                    TIMEOUT    = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    uart_pkt_deframer_if.slave    bus
);

    localparam int                    TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
    localparam logic [DATA_WIDTH-1:0] ONE_B     = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_csum;
    logic [DATA_WIDTH-1:0] r_remain;
    logic [TW-1:0]         r_tmo;
    logic                  r_out_vld;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic                  r_pkt_ok;
    logic                  r_pkt_err;
    logic [1:0]            r_err_code;

    logic                  w_in_rdy;
    logic                  w_hs;
    logic                  w_tmo_hit;
    logic                  w_load;
    logic                  w_ok;
    logic                  w_err;
    logic [1:0]            w_code;

    // Only the payload phase can back-pressure; it depends on registered state and out_rdy.
    always_comb begin
        w_in_rdy = 1'b1;
        if (r_state == S_PAYLOAD) begin
            w_in_rdy = !r_out_vld || bus.out_rdy_i;
        end
    end

    assign w_hs      = bus.in_vld_i && w_in_rdy;
    assign w_tmo_hit = (r_state != S_IDLE) && !w_hs && (r_tmo == TMO_LAST);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_code       = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (w_hs && (bus.in_data_i == SYNC_BYTE)) begin
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_hs) begin
                    if ((bus.in_data_i == '0) || (bus.in_data_i > MAX_LEN_B)) begin
                        w_state_next = S_IDLE;
                        w_err        = 1'b1;
                        w_code       = 2'd1;
                    end else begin
                        w_state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_hs) begin
                    w_load = 1'b1;
                    if (r_remain == ONE_B) begin
                        w_state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_hs) begin
                    w_state_next = S_IDLE;
                    if (bus.in_data_i == r_csum) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err  = 1'b1;
                        w_code = 2'd2;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // A stalled frame is abandoned; any byte already in the output register still drains.
        if (w_tmo_hit) begin
            w_state_next = S_IDLE;
            w_err        = 1'b1;
            w_code       = 2'd3;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_pkt_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= 2'd0;
            r_tmo      <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pkt_ok  <= w_ok;
            r_pkt_err <= w_err;
            if (w_err) begin
                r_err_code <= w_code;
            end
            if ((r_state == S_IDLE) || w_hs || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // LEN seeds the checksum so the transmitted checksum covers LEN and payload.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_csum   <= '0;
            r_remain <= '0;
        end else if (w_hs && (r_state == S_LEN)) begin
            r_csum   <= bus.in_data_i;
            r_remain <= bus.in_data_i;
        end else if (w_load) begin
            r_csum   <= r_csum ^ bus.in_data_i;
            r_remain <= r_remain - ONE_B;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (w_load) begin
            r_out_vld  <= 1'b1;
            r_out_data <= bus.in_data_i;
            r_out_last <= (r_remain == ONE_B);
        end else if (bus.out_rdy_i) begin
            r_out_vld  <= 1'b0;
        end
    end

    assign bus.in_rdy_o   = w_in_rdy;
    assign bus.out_vld_o  = r_out_vld;
    assign bus.out_data_o = r_out_data;
    assign bus.out_last_o = r_out_last;
    assign bus.pkt_ok_o   = r_pkt_ok;
    assign bus.pkt_err_o  = r_pkt_err;
    assign bus.err_code_o = r_err_code;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Randomised bench for uart_pkt_deframer: byte streams are parsed by a frame-level
// reference model and compared against the payload/status observed on the DUT.
module tb_uart_pkt_deframer;

    localparam int          MAX_LEN = 16;
    localparam int          TIMEOUT = 64;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_pkt_deframer_if #(.DATA_WIDTH(8)) bus ();

    uart_pkt_deframer #(
        .DATA_WIDTH (8),
        .SYNC_BYTE  (SYNC),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] stim[$];
    logic [8:0] exp_pay[$];  // {last, data}
    logic [8:0] got_pay[$];
    int         exp_st[$];   // 0 = ok, 1..3 = error code
    int         got_st[$];
    bit         mon_en    = 1'b0;
    bit         both_seen = 1'b0;
    bit         rdy_rand  = 1'b0;
    logic       rdy_force = 1'b1;
    int         gap_max   = 0;

    initial begin
        bus.out_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) bus.out_rdy_i = ($urandom_range(0, 3) != 0);
            else          bus.out_rdy_i = rdy_force;
        end
    end

    // Handshakes are sampled on the falling edge, where every signal is settled until the next rise.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (bus.out_vld_o && bus.out_rdy_i) got_pay.push_back({bus.out_last_o, bus.out_data_o});
                if (bus.pkt_ok_o && bus.pkt_err_o) both_seen = 1'b1;
                if (bus.pkt_ok_o)  got_st.push_back(0);
                if (bus.pkt_err_o) got_st.push_back(int'(bus.err_code_o));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level reference: walk the stream as a list of frames.
    task automatic model_parse();
        int i;
        int len;
        logic [7:0] cs;
        exp_pay.delete();
        exp_st.delete();
        i = 0;
        while (i < stim.size()) begin
            if (stim[i] != SYNC || i + 1 >= stim.size()) begin
                i++;
                continue;
            end
            len = int'(stim[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                exp_st.push_back(1);
                i += 2;
                continue;
            end
            cs = stim[i+1];
            for (int k = 0; k < len; k++) begin
                cs = cs ^ stim[i+2+k];
                exp_pay.push_back({(k == len - 1), stim[i+2+k]});
            end
            exp_st.push_back((stim[i+2+len] == cs) ? 0 : 2);
            i += len + 3;
        end
    endtask

    task automatic clear_got();
        got_pay.delete();
        got_st.delete();
        both_seen = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        bit took;
        waited = 0;
        took   = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        bus.in_vld_i  = 1'b1;
        bus.in_data_i = b;
        while (!took && waited < 1000) begin
            @(negedge clk);
            took = bus.in_rdy_o;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_vld_i  = 1'b0;
        bus.in_data_i = 8'($urandom_range(0, 255));
        checks++;
        if (!took) begin
            failures++;
            $display("FAIL send_byte: byte %h not accepted, in_rdy_o=%b required 1", b, bus.in_rdy_o);
        end
    endtask

    task automatic send_stream();
        foreach (stim[k]) send_byte(stim[k]);
    endtask

    task automatic drain();
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 4 && n < 500) begin
            @(negedge clk);
            n++;
            if (!bus.out_vld_o) quiet++;
            else quiet = 0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL drain: out_vld_o still %b after %0d cycles, required 0", bus.out_vld_o, n);
        end
    endtask

    task automatic do_reset();
        bus.in_vld_i  = 1'b0;
        bus.in_data_i = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_vld_i  = 1'b0;
        bus.in_data_i = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_rdy_o !== 1'b1 || bus.out_vld_o !== 1'b0 || bus.out_data_o !== 8'h00 || bus.out_last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stream: rdy=%b vld=%b data=%h last=%b, required 1 0 00 0",
                     bus.in_rdy_o, bus.out_vld_o, bus.out_data_o, bus.out_last_o);
        end
        checks++;
        if (bus.pkt_ok_o !== 1'b0 || bus.pkt_err_o !== 1'b0 || bus.err_code_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_status: ok=%b err=%b code=%0d, required 0 0 0",
                     bus.pkt_ok_o, bus.pkt_err_o, bus.err_code_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_rdy_o !== 1'b1 || bus.out_vld_o !== 1'b0 || bus.pkt_ok_o !== 1'b0 || bus.pkt_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: rdy=%b vld=%b ok=%b err=%b, required 1 0 0 0",
                     bus.in_rdy_o, bus.out_vld_o, bus.pkt_ok_o, bus.pkt_err_o);
        end
        @(posedge clk);
        #1;
        $display("[tb] reset: checked");
    endtask

    task automatic test_directed();
        int last_err;
        mon_en   = 1'b1;
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        for (int c = 0; c < 4; c++) begin
            gap_max = c;
            case (c)
                0: stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
                1: stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
                2: stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
                default: stim = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
            endcase
            if (c >= 2) rdy_rand = 1'b1;
            model_parse();
            clear_got();
            send_stream();
            drain();
            $display("[tb] directed %0d: payload=%0d status=%0d", c, got_pay.size(), got_st.size());
            checks++;
            if (got_pay.size() !== exp_pay.size()) begin
                failures++;
                $display("FAIL directed%0d payload_count: got %0d required %0d", c, got_pay.size(), exp_pay.size());
            end else begin
                foreach (exp_pay[k]) begin
                    checks++;
                    if (got_pay[k] !== exp_pay[k]) begin
                        failures++;
                        $display("FAIL directed%0d payload[%0d]: got %h required %h", c, k, got_pay[k], exp_pay[k]);
                    end
                end
            end
            checks++;
            if (got_st.size() !== exp_st.size()) begin
                failures++;
                $display("FAIL directed%0d status_count: got %0d required %0d", c, got_st.size(), exp_st.size());
            end else begin
                foreach (exp_st[k]) begin
                    checks++;
                    if (got_st[k] !== exp_st[k]) begin
                        failures++;
                        $display("FAIL directed%0d status[%0d]: got %0d required %0d", c, k, got_st[k], exp_st[k]);
                    end
                end
            end
            last_err = 0;
            foreach (exp_st[k]) if (exp_st[k] != 0) last_err = exp_st[k];
            if (last_err != 0) begin
                checks++;
                if (int'(bus.err_code_o) !== last_err) begin
                    failures++;
                    $display("FAIL directed%0d err_code_hold: got %0d required %0d", c, bus.err_code_o, last_err);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] pl[4];
        logic [7:0] cs;
        mon_en    = 1'b1;
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        gap_max   = 0;
        cs = 8'h04;
        foreach (pl[k]) begin
            pl[k] = 8'($urandom_range(0, 255));
            cs = cs ^ pl[k];
        end
        stim = '{SYNC, 8'h04, pl[0], pl[1], pl[2], pl[3], cs};
        model_parse();
        clear_got();
        send_byte(SYNC);
        send_byte(8'h04);
        rdy_force = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_byte(pl[0]);
        bus.in_vld_i  = 1'b1;
        bus.in_data_i = pl[1];
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (bus.in_rdy_o !== 1'b0 || bus.out_vld_o !== 1'b1 || bus.out_data_o !== pl[0] || bus.out_last_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: rdy=%b vld=%b data=%h last=%b, required 0 1 %h 0",
                         bus.in_rdy_o, bus.out_vld_o, bus.out_data_o, bus.out_last_o, pl[0]);
            end
        end
        @(posedge clk);
        #1;
        rdy_rand = 1'b1;
        for (int k = 1; k < 4; k++) send_byte(pl[k]);
        send_byte(cs);
        drain();
        $display("[tb] stall: payload=%0d status=%0d", got_pay.size(), got_st.size());
        checks++;
        if (got_pay.size() !== exp_pay.size()) begin
            failures++;
            $display("FAIL stall payload_count: got %0d required %0d", got_pay.size(), exp_pay.size());
        end else begin
            foreach (exp_pay[k]) begin
                checks++;
                if (got_pay[k] !== exp_pay[k]) begin
                    failures++;
                    $display("FAIL stall payload[%0d]: got %h required %h", k, got_pay[k], exp_pay[k]);
                end
            end
        end
        checks++;
        if (got_st.size() !== 1 || got_st[0] !== 0) begin
            failures++;
            $display("FAIL stall status: got %0d entries first=%0d required 1 entry 0",
                     got_st.size(), (got_st.size() > 0) ? got_st[0] : -1);
        end
    endtask

    task automatic test_timeout();
        int  lat;
        bit  seen;
        mon_en    = 1'b1;
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        gap_max   = 0;
        clear_got();
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'hAA);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < TIMEOUT + 20) begin
            @(negedge clk);
            lat++;
            if (bus.pkt_err_o) seen = 1'b1;
        end
        // lat-1 = clock edges from the AA handshake to the visible pulse.
        checks++;
        if (!seen || (lat - 1) < TIMEOUT - 1 || (lat - 1) > TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_latency: seen=%b after %0d cycles, required pulse after %0d +/-1",
                     seen, lat - 1, TIMEOUT);
        end
        checks++;
        if (bus.err_code_o !== 2'd3) begin
            failures++;
            $display("FAIL timeout_code: got %0d required 3", bus.err_code_o);
        end
        @(posedge clk);
        #1;
        drain();
        $display("[tb] timeout: latency=%0d payload=%0d status=%0d", lat - 1, got_pay.size(), got_st.size());
        checks++;
        if (got_pay.size() !== 1 || got_pay[0] !== 9'h0AA) begin
            failures++;
            $display("FAIL timeout_pending_byte: got %0d bytes first=%h required 1 byte 0aa",
                     got_pay.size(), (got_pay.size() > 0) ? got_pay[0] : 9'h1FF);
        end
        checks++;
        if (got_st.size() !== 1 || got_st[0] !== 3) begin
            failures++;
            $display("FAIL timeout_status: got %0d entries required exactly one code 3", got_st.size());
        end
        stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        model_parse();
        clear_got();
        send_stream();
        drain();
        // Idle must never time out.
        repeat (2 * TIMEOUT) @(posedge clk);
        #1;
        checks++;
        if (got_pay.size() !== exp_pay.size() || got_st.size() !== 1 || got_st[0] !== 0) begin
            failures++;
            $display("FAIL timeout_recover: payload %0d status %0d, required payload %0d and single ok",
                     got_pay.size(), got_st.size(), exp_pay.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] cs;
        int len;
        int kind;
        int last_err;
        mon_en   = 1'b1;
        rdy_rand = 1'b1;
        gap_max  = 2;
        stim.delete();
        repeat (25) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                stim.push_back(b);
            end
            kind = $urandom_range(0, 9);
            stim.push_back(SYNC);
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 0) stim.push_back(8'h00);
                else stim.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = $urandom_range(1, MAX_LEN);
                cs  = 8'(len);
                stim.push_back(8'(len));
                repeat (len) begin
                    b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
                    stim.push_back(b);
                    cs = cs ^ b;
                end
                if (kind == 1) cs = cs ^ 8'($urandom_range(1, 255));
                stim.push_back(cs);
            end
        end
        model_parse();
        clear_got();
        send_stream();
        drain();
        $display("[tb] random: bytes=%0d payload=%0d status=%0d", stim.size(), got_pay.size(), got_st.size());
        checks++;
        if (got_pay.size() !== exp_pay.size()) begin
            failures++;
            $display("FAIL random payload_count: got %0d required %0d", got_pay.size(), exp_pay.size());
        end else begin
            foreach (exp_pay[k]) begin
                checks++;
                if (got_pay[k] !== exp_pay[k]) begin
                    failures++;
                    $display("FAIL random payload[%0d]: got %h required %h", k, got_pay[k], exp_pay[k]);
                end
            end
        end
        checks++;
        if (got_st.size() !== exp_st.size()) begin
            failures++;
            $display("FAIL random status_count: got %0d required %0d", got_st.size(), exp_st.size());
        end else begin
            foreach (exp_st[k]) begin
                checks++;
                if (got_st[k] !== exp_st[k]) begin
                    failures++;
                    $display("FAIL random status[%0d]: got %0d required %0d", k, got_st[k], exp_st[k]);
                end
            end
        end
        checks++;
        if (both_seen !== 1'b0) begin
            failures++;
            $display("FAIL random ok_err_exclusive: both pulses seen together, required never");
        end
        last_err = 0;
        foreach (exp_st[k]) if (exp_st[k] != 0) last_err = exp_st[k];
        if (last_err != 0) begin
            checks++;
            if (int'(bus.err_code_o) !== last_err) begin
                failures++;
                $display("FAIL random err_code_hold: got %0d required %0d", bus.err_code_o, last_err);
            end
        end
    endtask

    task automatic test_reset_midframe();
        mon_en    = 1'b1;
        rdy_rand  = 1'b0;
        rdy_force = 1'b0;
        gap_max   = 0;
        clear_got();
        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h11);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_rdy_o !== 1'b1 || bus.out_vld_o !== 1'b0 || bus.out_data_o !== 8'h00 || bus.out_last_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_stream: rdy=%b vld=%b data=%h last=%b, required 1 0 00 0",
                     bus.in_rdy_o, bus.out_vld_o, bus.out_data_o, bus.out_last_o);
        end
        checks++;
        if (bus.pkt_ok_o !== 1'b0 || bus.pkt_err_o !== 1'b0 || bus.err_code_o !== 2'd0 || got_st.size() !== 0) begin
            failures++;
            $display("FAIL midreset_status: ok=%b err=%b code=%0d pulses=%0d, required 0 0 0 0",
                     bus.pkt_ok_o, bus.pkt_err_o, bus.err_code_o, got_st.size());
        end
        rdy_rand = 1'b1;
        do_reset();
        stim = '{8'hA5, 8'h01, 8'hC3, 8'hC2};
        model_parse();
        clear_got();
        send_stream();
        drain();
        $display("[tb] reset_midframe: payload=%0d status=%0d", got_pay.size(), got_st.size());
        checks++;
        if (got_pay.size() !== 1 || got_pay[0] !== 9'h1C3 || got_st.size() !== 1 || got_st[0] !== 0) begin
            failures++;
            $display("FAIL midreset_next_frame: payload %0d status %0d, required one byte 1c3 and single ok",
                     got_pay.size(), got_st.size());
        end
    endtask

    initial begin
        bus.in_vld_i  = 1'b0;
        bus.in_data_i = 8'h00;
        test_reset();
        test_directed();
        test_stall();
        test_timeout();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
